// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package hazard_ctrl_pkg;

    // Operand source select for the execute-stage operand muxes.
    typedef enum logic [1:0] {
        REG = 2'b00,
        MEM = 2'b01,
        WB  = 2'b10
    } hu_src_e;

    // Hazard controller sequencing states.
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        REDIR1  = 2'b01,
        REDIR2  = 2'b10,
        MC_WAIT = 2'b11
    } hc_state_e;

    localparam int unsigned REG_ADDR_W = 5;

    // A later stage produces the value of `rs` when it writes a matching,
    // non-zero destination; x0 is hard-wired and never forwarded.
    function automatic logic src_match(
        input logic                  we,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs
    );
        return we && (rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - single-operand forwarding comparator
module hazard_ctrl_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic       en,
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output hu_src_e    src
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = src_match(mem_reg_write, mem_rd, ex_rs);
    assign hit_wb  = src_match(wb_reg_write, wb_rd, ex_rs);

    // MEM holds the younger result, so it wins over WB when both match.
    always_comb begin
        src = REG;
        if (en) begin
            if (hit_mem) begin
                src = MEM;
            end else if (hit_wb) begin
                src = WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use stall, redirect flush and multi-cycle hold control
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic             de_use_rs1,
    input  logic             de_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_v,
    input  logic             ex_mem_read,
    input  logic             ex_mc_start,
    input  logic             mc_done,
    input  logic             pc_reset,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    output hu_src_e          rs1s,
    output hu_src_e          rs2s,
    output logic             stall_f,
    output logic             stall_d,
    output logic             bubble_d,
    output logic             stall_e,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hc_state_e        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic in_run;
    logic dep_rs1;
    logic dep_rs2;
    logic ld_use;
    logic mc_begin;

    hazard_ctrl_fwd_sel u_fwd_rs1 (
        .en            (!reset),
        .ex_rs         (ex_rs1),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .src           (rs1s)
    );

    hazard_ctrl_fwd_sel u_fwd_rs2 (
        .en            (!reset),
        .ex_rs         (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .src           (rs2s)
    );

    // Hazard detection: a load in execute feeding decode, and a multi-cycle op
    // that will not finish this cycle. A taken redirect kills both consumers,
    // so it masks the load-use check.
    always_comb begin
        in_run   = !reset && (state_q == RUN);
        dep_rs1  = de_use_rs1 && (de_rs1 == ex_rd);
        dep_rs2  = de_use_rs2 && (de_rs2 == ex_rd);
        ld_use   = in_run && !pc_reset && ex_v && ex_mem_read &&
                   (ex_rd != 5'd0) && (dep_rs1 || dep_rs2);
        mc_begin = in_run && !pc_reset && ex_v && ex_mc_start && !mc_done;
    end

    // Stall/bubble outputs; a held execute stage must keep the decode
    // instruction intact, so no bubble is injected while stall_e is high.
    always_comb begin
        stall_e  = mc_begin || (!reset && (state_q == MC_WAIT) && !mc_done);
        stall_f  = ld_use || stall_e;
        stall_d  = stall_f;
        bubble_d = ld_use && !stall_e;
        flush    = (state_q == REDIR1) || (state_q == REDIR2);
    end

    // Next-state logic: redirect beats multi-cycle start in RUN.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (pc_reset) begin
                    state_d = REDIR1;
                end else if (ex_v && ex_mc_start && !mc_done) begin
                    state_d = MC_WAIT;
                end
            end
            REDIR1: state_d = REDIR2;
            REDIR2: state_d = RUN;
            MC_WAIT: begin
                if (mc_done) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Performance counters wrap naturally at 2^CNT_W.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_f};
        flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, flush};
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    typedef logic [74:0] exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        de_use_rs1, de_use_rs2, ex_v, ex_mem_read, ex_mc_start;
    logic        mc_done, pc_reset, mem_reg_write, wb_reg_write;
    hu_src_e     rs1s, rs2s;
    logic        stall_f, stall_d, bubble_d, stall_e, flush;
    logic [31:0] stall_cnt, flush_cnt;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .de_rs1        (de_rs1),
        .de_rs2        (de_rs2),
        .de_use_rs1    (de_use_rs1),
        .de_use_rs2    (de_use_rs2),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_v          (ex_v),
        .ex_mem_read   (ex_mem_read),
        .ex_mc_start   (ex_mc_start),
        .mc_done       (mc_done),
        .pc_reset      (pc_reset),
        .mem_rd        (mem_rd),
        .wb_rd         (wb_rd),
        .mem_reg_write (mem_reg_write),
        .wb_reg_write  (wb_reg_write),
        .rs1s          (rs1s),
        .rs2s          (rs2s),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .bubble_d      (bubble_d),
        .stall_e       (stall_e),
        .flush         (flush),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    task automatic idle();
        de_rs1 = 0; de_rs2 = 0; de_use_rs1 = 0; de_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_v = 0; ex_mem_read = 0;
        ex_mc_start = 0; mc_done = 0; pc_reset = 0;
        mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0;
    endtask

    // Expected: rs1s, rs2s, stall_f(=stall_d), bubble_d, stall_e, flush, counters, state.
    task automatic push(input string tag, input logic [1:0] r1, input logic [1:0] r2,
                        input logic sf, input logic bd, input logic se, input logic fl,
                        input logic [31:0] sc, input logic [31:0] fc, input logic [1:0] st);
        exp_q.push_back({r1, r2, sf, sf, bd, se, fl, sc, fc, st});
        tag_q.push_back(tag);
    endtask

    task automatic check_now();
        exp_t  e;
        exp_t  g;
        string t;
        #2;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            g = {rs1s, rs2s, stall_f, stall_d, bubble_d, stall_e, flush,
                 stall_cnt, flush_cnt, 2'(dut.state_q)};
            assert (g === e) else begin
                n_bad++;
                $error("FAIL %s observed=%h expected=%h", t, g, e);
            end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        @(negedge clk);
        // reset held: forwarding match must still read REG
        ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1;
        push("reset_state", REG, REG, 0, 0, 0, 0, 0, 0, RUN); check_now();

        @(negedge clk); reset = 1'b0; idle();
        ex_rs1 = 5; mem_rd = 5; wb_rd = 5; mem_reg_write = 1; wb_reg_write = 1;
        push("fwd_mem_beats_wb", MEM, REG, 0, 0, 0, 0, 0, 0, RUN); check_now();

        @(negedge clk); mem_reg_write = 0;
        push("fwd_wb", WB, REG, 0, 0, 0, 0, 0, 0, RUN); check_now();

        @(negedge clk); idle(); ex_rs2 = 0; mem_rd = 0; mem_reg_write = 1;
        push("fwd_x0_reg", REG, REG, 0, 0, 0, 0, 0, 0, RUN); check_now();

        @(negedge clk); idle(); ex_rs1 = 9; ex_rs2 = 4; mem_rd = 9; mem_reg_write = 1;
        wb_rd = 4; wb_reg_write = 1;
        push("fwd_rs1_mem_rs2_wb", MEM, WB, 0, 0, 0, 0, 0, 0, RUN); check_now();

        // load-use: lw x3 in execute, decode reads x3 on rs2
        @(negedge clk); idle(); ex_v = 1; ex_mem_read = 1; ex_rd = 3; de_rs2 = 3; de_use_rs2 = 1;
        push("ld_use_stall", REG, REG, 1, 1, 0, 0, 0, 0, RUN); check_now();

        @(negedge clk); idle();
        push("ld_use_release", REG, REG, 0, 0, 0, 0, 1, 0, RUN); check_now();

        @(negedge clk); idle(); ex_v = 1; ex_mem_read = 1; ex_rd = 3; de_rs2 = 3;
        push("ld_no_use", REG, REG, 0, 0, 0, 0, 1, 0, RUN); check_now();

        @(negedge clk); idle(); ex_v = 1; ex_mem_read = 1; ex_rd = 0; de_use_rs1 = 1;
        push("ld_x0", REG, REG, 0, 0, 0, 0, 1, 0, RUN); check_now();

        // redirect with a concurrent load-use condition
        @(negedge clk); idle(); pc_reset = 1; ex_v = 1; ex_mem_read = 1; ex_rd = 3;
        de_rs1 = 3; de_use_rs1 = 1;
        push("redir_t", REG, REG, 0, 0, 0, 0, 1, 0, RUN); check_now();
        @(negedge clk); pc_reset = 0;
        push("redir_t1", REG, REG, 0, 0, 0, 1, 1, 0, REDIR1); check_now();
        @(negedge clk); idle();
        push("redir_t2", REG, REG, 0, 0, 0, 1, 1, 1, REDIR2); check_now();
        @(negedge clk);
        push("redir_t3", REG, REG, 0, 0, 0, 0, 1, 2, RUN); check_now();

        // multi-cycle op, done four cycles later; load-use at start gives no bubble
        @(negedge clk); idle(); ex_v = 1; ex_mc_start = 1; ex_mem_read = 1; ex_rd = 6;
        de_rs1 = 6; de_use_rs1 = 1;
        push("mc_t", REG, REG, 1, 0, 1, 0, 1, 2, RUN); check_now();
        @(negedge clk); push("mc_t1", REG, REG, 1, 0, 1, 0, 2, 2, MC_WAIT); check_now();
        @(negedge clk); push("mc_t2", REG, REG, 1, 0, 1, 0, 3, 2, MC_WAIT); check_now();
        @(negedge clk); push("mc_t3", REG, REG, 1, 0, 1, 0, 4, 2, MC_WAIT); check_now();
        @(negedge clk); mc_done = 1;
        push("mc_t4", REG, REG, 0, 0, 0, 0, 5, 2, MC_WAIT); check_now();
        @(negedge clk); idle();
        push("mc_t5", REG, REG, 0, 0, 0, 0, 5, 2, RUN); check_now();

        // single-cycle multi-cycle op
        @(negedge clk); ex_v = 1; ex_mc_start = 1; mc_done = 1;
        push("mc_k0", REG, REG, 0, 0, 0, 0, 5, 2, RUN); check_now();
        @(negedge clk); idle();
        push("mc_k0_next", REG, REG, 0, 0, 0, 0, 5, 2, RUN); check_now();

        // reset during MC_WAIT after two stall cycles
        @(negedge clk); ex_v = 1; ex_mc_start = 1;
        push("mcr_t", REG, REG, 1, 0, 1, 0, 5, 2, RUN); check_now();
        @(negedge clk);
        push("mcr_t1", REG, REG, 1, 0, 1, 0, 6, 2, MC_WAIT); check_now();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; idle();
        push("mcr_after_reset", REG, REG, 0, 0, 0, 0, 0, 0, RUN); check_now();

        // redirect after reset, then a back-to-back redirect in t+3
        @(negedge clk); pc_reset = 1;
        push("p_t", REG, REG, 0, 0, 0, 0, 0, 0, RUN); check_now();
        @(negedge clk); pc_reset = 0;
        push("p_t1", REG, REG, 0, 0, 0, 1, 0, 0, REDIR1); check_now();
        @(negedge clk); push("p_t2", REG, REG, 0, 0, 0, 1, 0, 1, REDIR2); check_now();
        @(negedge clk); pc_reset = 1;
        push("p_t3", REG, REG, 0, 0, 0, 0, 0, 2, RUN); check_now();
        @(negedge clk); pc_reset = 0;
        push("p_t4", REG, REG, 0, 0, 0, 1, 0, 2, REDIR1); check_now();
        @(negedge clk); push("p_t5", REG, REG, 0, 0, 0, 1, 0, 3, REDIR2); check_now();
        @(negedge clk); push("p_t6", REG, REG, 0, 0, 0, 0, 0, 4, RUN); check_now();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
